// File: rtl/bf_capture_pkg.sv
// ---------------------------------------------------------------------------
// bf_capture_pkg
// Shared definitions for the Blackfin ping-pong ADC capture buffer:
//   - capState_t   : capture state encoding (ARMED / SYNC / RUN)
//   - STAT_*       : bit positions inside the 16-bit status word
//   - clog2()      : ceiling log2 usable in constant expressions
//   - chanWidth()  : channel index width, never narrower than one bit
// ---------------------------------------------------------------------------
package bf_capture_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'b00,
        ST_SYNC  = 2'b01,
        ST_RUN   = 2'b10
    } capState_t;

    localparam int STAT_SYNCERR  = 15;
    localparam int STAT_OVERRUN  = 14;
    localparam int STAT_BANKLAST = 13;
    localparam int STAT_DATARDY  = 12;
    localparam int STAT_WRBANK   = 11;
    localparam int STAT_STATE_LO = 9;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int chanWidth(input int numCh);
        return (numCh > 1) ? clog2(numCh) : 1;
    endfunction

endpackage

// File: rtl/capture_dpram.sv
// ---------------------------------------------------------------------------
// capture_dpram
// Simple dual-port RAM holding both ping-pong banks. One write port fed by
// the ADC side, one read port with a single registered stage for the host.
// A read and a write to the same word in one cycle return the old contents.
// Ports:
//   I_clk   in  1       clock
//   wrEn    in  1       write strobe
//   wrAddr  in  AW      write word address ({bank, offset})
//   wrData  in  DATA_W  write data
//   rdEn    in  1       read strobe, updates rdData at the clock edge
//   rdAddr  in  AW      read word address
//   rdData  out DATA_W  registered read data
// ---------------------------------------------------------------------------
module capture_dpram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int AW     = 12
) (
    input  logic              I_clk,
    input  logic              wrEn,
    input  logic [AW-1:0]     wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [AW-1:0]     rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array with a registered read; no reset so it maps onto block RAM.
    always_ff @(posedge I_clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/bf_capture_pingpong.sv
// ---------------------------------------------------------------------------
// bf_capture_pingpong
// Multi-channel ADC capture into a ping-pong RAM (bank A/B) that the Blackfin
// reads over its async memory bus with one ARDY wait-state. Checks channel
// framing, flags overruns and exposes a status word.
// Optional feature macro: CAPTURE_TRIG_EN (adds I_trigLevel / I_rearm and the
// ARMED state, capture then starts on a level trigger instead of at reset).
// Ports:
//   I_clk, I_rst_n          clock, synchronous active-low reset
//   ADC_I_dataValid/chan/data  interleaved sample stream
//   BF_I_addr/bankSelect/are   host read request
//   BF_OT_dataBus, BF_O_ardy   tri-state read data and ready
//   I_dataRead              host consumed the completed bank
//   O_dataRdy, O_bankLastFilled, O_overrun, O_syncErr  status flags
// ---------------------------------------------------------------------------
module bf_capture_pingpong
    import bf_capture_pkg::*;
#(
    parameter int         DATA_W     = 16,
    parameter int         NUM_CH     = 4,
    parameter int         BANK_DEPTH = 2048,
    parameter int         ADDR_W     = 16,
    parameter logic [1:0] REGION     = 2'b00
) (
    input  logic                         I_clk,
    input  logic                         I_rst_n,
    input  logic                         ADC_I_dataValid,
    input  logic [chanWidth(NUM_CH)-1:0] ADC_I_chan,
    input  logic [DATA_W-1:0]            ADC_I_data,
    input  logic [ADDR_W-1:0]            BF_I_addr,
    input  logic                         BF_I_bankSelect,
    input  logic                         BF_I_are,
    output logic [15:0]                  BF_OT_dataBus,
    output logic                         BF_O_ardy,
    input  logic                         I_dataRead,
`ifdef CAPTURE_TRIG_EN
    input  logic [DATA_W-1:0]            I_trigLevel,
    input  logic                         I_rearm,
`endif
    output logic                         O_dataRdy,
    output logic                         O_bankLastFilled,
    output logic                         O_overrun,
    output logic                         O_syncErr
);

    localparam int CW = chanWidth(NUM_CH);
    localparam int AW = clog2(BANK_DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(BANK_DEPTH - 1);
    localparam logic [AW-1:0] FRAME_MASK = ~AW'(NUM_CH - 1);
`ifdef CAPTURE_TRIG_EN
    localparam capState_t RESET_STATE = ST_ARMED;
`else
    localparam capState_t RESET_STATE = ST_SYNC;
`endif

    capState_t         state, stateNext;
    logic [AW-1:0]     wrPtr, wrPtrNext;
    logic              wrBank, wrBankNext;
    logic              wrEn, bankDone, syncErrSet;
    logic              chanZero, chanOk;
    logic              regionHit, rdReq, isStatus, busDrive, ramRdEn;
    logic              rdValid, rdIsStatus;
    logic [ADDR_W-1:0] rdAddrQ;
    logic [15:0]       statusWord, statusQ;
    logic [DATA_W-1:0] ramRdData;

    assign chanZero = (ADC_I_chan == '0);

    // With a single channel every sample is in its slot, so framing cannot fail.
    generate
        if (NUM_CH == 1) begin : gSingleCh
            assign chanOk = 1'b1;
        end else begin : gMultiCh
            assign chanOk = (ADC_I_chan == wrPtr[CW-1:0]);
        end
    endgenerate

`ifdef CAPTURE_TRIG_EN
    logic [DATA_W-1:0] sampleMag;
    logic              trigHit;

    // Unsigned magnitude of the sample; the most negative code saturates.
    always_comb begin
        sampleMag = ADC_I_data;
        if (ADC_I_data[DATA_W-1]) begin
            if (ADC_I_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
                sampleMag = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                sampleMag = -ADC_I_data;
            end
        end
    end

    assign trigHit = (sampleMag >= I_trigLevel);
`endif

    // Capture FSM next state plus write pointer bookkeeping. A write at the
    // last word of a bank wraps the pointer and flips to the other bank.
    always_comb begin
        stateNext  = state;
        wrPtrNext  = wrPtr;
        wrBankNext = wrBank;
        wrEn       = 1'b0;
        bankDone   = 1'b0;
        syncErrSet = 1'b0;
        case (state)
`ifdef CAPTURE_TRIG_EN
            ST_ARMED: begin
                if (ADC_I_dataValid && chanZero && trigHit) begin
                    wrEn      = 1'b1;
                    stateNext = ST_RUN;
                end
            end
`endif
            ST_SYNC: begin
                if (ADC_I_dataValid && chanZero) begin
                    wrEn      = 1'b1;
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ADC_I_dataValid) begin
                    if (chanOk) begin
                        wrEn = 1'b1;
                    end else begin
                        syncErrSet = 1'b1;
                        wrPtrNext  = wrPtr & FRAME_MASK;
                        stateNext  = ST_SYNC;
                    end
                end
            end
            default: stateNext = RESET_STATE;
        endcase
        if (wrEn) begin
            if (wrPtr == LAST_PTR) begin
                wrPtrNext  = '0;
                wrBankNext = ~wrBank;
                bankDone   = 1'b1;
            end else begin
                wrPtrNext = wrPtr + 1'b1;
            end
        end
`ifdef CAPTURE_TRIG_EN
        // Re-arm overrides whatever the current sample would have done.
        if (I_rearm) begin
            stateNext  = ST_ARMED;
            wrPtrNext  = '0;
            wrBankNext = 1'b0;
            wrEn       = 1'b0;
            bankDone   = 1'b0;
            syncErrSet = 1'b0;
        end
`endif
    end

    // Capture state and write pointer registers.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state  <= RESET_STATE;
            wrPtr  <= '0;
            wrBank <= 1'b0;
        end else begin
            state  <= stateNext;
            wrPtr  <= wrPtrNext;
            wrBank <= wrBankNext;
        end
    end

    // Host handshake and sticky flags. A bank completion beats a same-cycle ack.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            O_dataRdy        <= 1'b0;
            O_bankLastFilled <= 1'b0;
            O_overrun        <= 1'b0;
            O_syncErr        <= 1'b0;
        end else begin
            if (syncErrSet) begin
                O_syncErr <= 1'b1;
            end
            if (bankDone) begin
                O_dataRdy        <= 1'b1;
                O_bankLastFilled <= wrBank;
                if (O_dataRdy) begin
                    O_overrun <= 1'b1;
                end
            end else if (I_dataRead) begin
                O_dataRdy <= 1'b0;
            end
`ifdef CAPTURE_TRIG_EN
            if (I_rearm) begin
                O_dataRdy <= 1'b0;
            end
`endif
        end
    end

    // Host address decode; addr[AW+1] selects the status word over RAM.
    assign regionHit = (BF_I_addr[ADDR_W-1 -: 2] == REGION) && BF_I_bankSelect;
    assign rdReq     = regionHit && BF_I_are;
    assign isStatus  = BF_I_addr[AW+1];
    assign ramRdEn   = rdReq && !isStatus;
    assign busDrive  = rdReq && I_rst_n;

    always_comb begin
        statusWord                                 = '0;
        statusWord[STAT_SYNCERR]                   = O_syncErr;
        statusWord[STAT_OVERRUN]                   = O_overrun;
        statusWord[STAT_BANKLAST]                  = O_bankLastFilled;
        statusWord[STAT_DATARDY]                   = O_dataRdy;
        statusWord[STAT_WRBANK]                    = wrBank;
        statusWord[STAT_STATE_LO+1:STAT_STATE_LO]  = state;
    end

    // Read pipeline: the address is latched with the data so that a changed
    // address while ARE stays high drops ARDY for one more wait cycle.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            rdValid    <= 1'b0;
            rdIsStatus <= 1'b0;
            rdAddrQ    <= '0;
            statusQ    <= '0;
        end else begin
            rdValid <= rdReq;
            if (rdReq) begin
                rdAddrQ    <= BF_I_addr;
                rdIsStatus <= isStatus;
                statusQ    <= statusWord;
            end
        end
    end

    assign BF_OT_dataBus = busDrive ? (rdIsStatus ? statusQ : 16'(ramRdData)) : 'z;
    assign BF_O_ardy     = busDrive ? (rdValid && (BF_I_addr == rdAddrQ)) : 1'bz;

    capture_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (2 * BANK_DEPTH),
        .AW     (AW + 1)
    ) ram (
        .I_clk  (I_clk),
        .wrEn   (wrEn),
        .wrAddr ({wrBank, wrPtr}),
        .wrData (ADC_I_data),
        .rdEn   (ramRdEn),
        .rdAddr (BF_I_addr[AW:0]),
        .rdData (ramRdData)
    );

endmodule

// File: tb/tb_bf_capture_pingpong.sv
// ---------------------------------------------------------------------------
// tb_bf_capture_pingpong
// Directed bench for bf_capture_pingpong (NUM_CH=4, BANK_DEPTH=16, DATA_W=12).
// A bank/pointer level model predicts the flags every cycle and the RAM
// contents; literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_bf_capture_pingpong;

    localparam int DATA_W     = 12;
    localparam int NUM_CH     = 4;
    localparam int BANK_DEPTH = 16;
    localparam int ADDR_W     = 16;
    localparam logic [15:0] STATUS_ADDR = 16'h0020;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        adcValid = 1'b0;
    logic [1:0]  adcChan = '0;
    logic [11:0] adcData = '0;
    logic [15:0] bfAddr = '0;
    logic        bfSel = 1'b0;
    logic        bfAre = 1'b0;
    logic        dataRead = 1'b0;
    wire  [15:0] dataBus;
    wire         ardy;
    logic        dataRdy, bankLast, overrun, syncErr;

    pullup puBus (dataBus);

    int compared = 0;
    int mismatched = 0;

    // Behavioural model: bank contents plus the flags the host sees.
    bit mSynced;
    int mPtr, mBank;
    bit mRdy, mLast, mOver, mErr;
    int mMem [2*BANK_DEPTH];
    bit checkFlags = 1'b0;

    always #5 I_clk = ~I_clk;

`ifdef CAPTURE_TRIG_EN
    logic [11:0] trigLevel = '0;
    logic        rearm = 1'b0;
`endif

    bf_capture_pingpong #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .BANK_DEPTH (BANK_DEPTH),
        .ADDR_W     (ADDR_W),
        .REGION     (2'b00)
    ) dut (
        .I_clk            (I_clk),
        .I_rst_n          (I_rst_n),
        .ADC_I_dataValid  (adcValid),
        .ADC_I_chan       (adcChan),
        .ADC_I_data       (adcData),
        .BF_I_addr        (bfAddr),
        .BF_I_bankSelect  (bfSel),
        .BF_I_are         (bfAre),
        .BF_OT_dataBus    (dataBus),
        .BF_O_ardy        (ardy),
        .I_dataRead       (dataRead),
`ifdef CAPTURE_TRIG_EN
        .I_trigLevel      (trigLevel),
        .I_rearm          (rearm),
`endif
        .O_dataRdy        (dataRdy),
        .O_bankLastFilled (bankLast),
        .O_overrun        (overrun),
        .O_syncErr        (syncErr)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    function automatic logic busIdle();
        return (dataBus === 16'hFFFF) || (dataBus === 16'hzzzz);
    endfunction

    function automatic logic [15:0] modelStatus();
        logic [15:0] s;
        s = '0;
        s[15] = mErr;
        s[14] = mOver;
        s[13] = mLast;
        s[12] = mRdy;
        s[11] = mBank[0];
        s[10:9] = mSynced ? 2'b10 : 2'b01;
        return s;
    endfunction

    // One model step per clock edge, using the inputs that edge samples.
    task automatic modelStep();
        bit done;
        bit doWrite;
        int oldBank;
        done = 1'b0;
        doWrite = 1'b0;
        oldBank = mBank;
        if (!I_rst_n) begin
            mSynced = 1'b0; mPtr = 0; mBank = 0;
            mRdy = 1'b0; mLast = 1'b0; mOver = 1'b0; mErr = 1'b0;
            return;
        end
        if (adcValid) begin
            if (!mSynced) begin
                if (adcChan == 2'd0) begin
                    doWrite = 1'b1;
                    mSynced = 1'b1;
                end
            end else if (int'(adcChan) != (mPtr % NUM_CH)) begin
                mErr = 1'b1;
                mPtr = (mPtr / NUM_CH) * NUM_CH;
                mSynced = 1'b0;
            end else begin
                doWrite = 1'b1;
            end
        end
        if (doWrite) begin
            mMem[mBank*BANK_DEPTH + mPtr] = int'(adcData);
            mPtr++;
            if (mPtr == BANK_DEPTH) begin
                mPtr = 0;
                mBank ^= 1;
                done = 1'b1;
            end
        end
        if (done) begin
            if (mRdy) mOver = 1'b1;
            mRdy = 1'b1;
            mLast = oldBank[0];
        end else if (dataRead) begin
            mRdy = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge I_clk);
            modelStep();
        end
    end

    // Per-cycle flag comparison against the model.
    initial begin
        forever begin
            @(negedge I_clk);
            if (checkFlags) begin
                checkOutput("cyc.dataRdy",  16'(dataRdy),  16'(mRdy));
                checkOutput("cyc.bankLast", 16'(bankLast), 16'(mLast));
                checkOutput("cyc.overrun",  16'(overrun),  16'(mOver));
                checkOutput("cyc.syncErr",  16'(syncErr),  16'(mErr));
            end
        end
    end

    task automatic applyStimulus(input bit valid, input int chan, input int data, input bit ack);
        @(posedge I_clk);
        #1;
        adcValid = valid;
        adcChan  = chan[1:0];
        adcData  = data[11:0];
        dataRead = ack;
    endtask

    task automatic fillSamples(input int first, input int count, input int base, input bit ackLast);
        for (int p = first; p < first + count; p++) begin
            applyStimulus(1'b1, p % NUM_CH, base + p, ackLast && (p == first + count - 1));
        end
        applyStimulus(1'b0, 0, 0, 1'b0);
    endtask

    task automatic busRead(input logic [15:0] addr, input logic [15:0] expData, input int hold,
                           input string name, output logic [15:0] got);
        @(posedge I_clk);
        #1;
        bfAddr = addr; bfSel = 1'b1; bfAre = 1'b1;
        @(negedge I_clk);
        checkOutput({name, ".ardyWait"}, 16'(ardy), 16'h0000);
        checkOutput({name, ".drivenWait"}, 16'(busIdle()), 16'h0000);
        got = dataBus;
        for (int k = 1; k < hold; k++) begin
            @(negedge I_clk);
            checkOutput({name, ".ardy"}, 16'(ardy), 16'h0001);
            checkOutput({name, ".data"}, dataBus, expData);
            got = dataBus;
        end
        @(posedge I_clk);
        #1;
        bfAre = 1'b0; bfSel = 1'b0;
        @(negedge I_clk);
        checkOutput({name, ".released"}, 16'(busIdle()), 16'h0001);
    endtask

    task automatic busReadSwitch(input logic [15:0] addrA, input logic [15:0] addrB);
        @(posedge I_clk);
        #1;
        bfAddr = addrA; bfSel = 1'b1; bfAre = 1'b1;
        @(negedge I_clk);
        checkOutput("sw.ardyA0", 16'(ardy), 16'h0000);
        @(negedge I_clk);
        checkOutput("sw.ardyA1", 16'(ardy), 16'h0001);
        checkOutput("sw.dataA", dataBus, 16'(mMem[addrA[4:0]]));
        @(posedge I_clk);
        #1;
        bfAddr = addrB;
        @(negedge I_clk);
        checkOutput("sw.ardyB0", 16'(ardy), 16'h0000);
        @(negedge I_clk);
        checkOutput("sw.ardyB1", 16'(ardy), 16'h0001);
        checkOutput("sw.dataB", dataBus, 16'(mMem[addrB[4:0]]));
        @(posedge I_clk);
        #1;
        bfAre = 1'b0; bfSel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] got;
        logic [15:0] idleStatus;

        // Reset state
        I_rst_n = 1'b0;
        repeat (3) @(posedge I_clk);
        @(negedge I_clk);
        checkOutput("rst.dataRdy",  16'(dataRdy),  16'h0000);
        checkOutput("rst.bankLast", 16'(bankLast), 16'h0000);
        checkOutput("rst.overrun",  16'(overrun),  16'h0000);
        checkOutput("rst.syncErr",  16'(syncErr),  16'h0000);
        checkOutput("rst.busZ",     16'(busIdle()), 16'h0001);
        @(posedge I_clk);
        #1;
        I_rst_n = 1'b1;
        checkFlags = 1'b1;

`ifdef CAPTURE_TRIG_EN
        idleStatus = 16'h0000;
`else
        idleStatus = 16'h0200;
`endif
        busRead(STATUS_ADDR, idleStatus, 2, "statusIdle", got);

        // First bank: 0x100+i, channels cycling 0..3
        fillSamples(0, BANK_DEPTH, 16'h100, 1'b0);
        @(negedge I_clk);
        checkOutput("bank1.dataRdy",  16'(dataRdy),  16'h0001);
        checkOutput("bank1.bankLast", 16'(bankLast), 16'h0000);
        for (int i = 0; i < BANK_DEPTH; i++) begin
            busRead(16'(i), 16'(mMem[i]), 2, $sformatf("ram%0d", i), got);
        end
        busRead(16'h0005, 16'h0105, 3, "hold5", got);
        busReadSwitch(16'h0002, 16'h0003);

        // Region miss and chip-select low leave the bus released
        @(posedge I_clk);
        #1;
        bfAddr = 16'h4005; bfSel = 1'b1; bfAre = 1'b1;
        @(negedge I_clk);
        checkOutput("regionMiss.busZ", 16'(busIdle()), 16'h0001);
        @(posedge I_clk);
        #1;
        bfAddr = 16'h0005; bfSel = 1'b0;
        @(negedge I_clk);
        checkOutput("selLow.busZ", 16'(busIdle()), 16'h0001);
        @(posedge I_clk);
        #1;
        bfAre = 1'b0;

        // Ack the first bank
        applyStimulus(1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b0);
        @(negedge I_clk);
        checkOutput("ack1.dataRdy", 16'(dataRdy), 16'h0000);

        // Second bank fills B, no overrun yet
        fillSamples(0, BANK_DEPTH, 16'h200, 1'b0);
        @(negedge I_clk);
        checkOutput("bank2.bankLast", 16'(bankLast), 16'h0001);
        checkOutput("bank2.overrun",  16'(overrun),  16'h0000);
        busRead(16'h0013, 16'h0203, 2, "bankB3", got);

        // Third bank completes with dataRdy still set
        fillSamples(0, BANK_DEPTH, 16'h300, 1'b0);
        @(negedge I_clk);
        checkOutput("bank3.overrun",  16'(overrun),  16'h0001);
        checkOutput("bank3.bankLast", 16'(bankLast), 16'h0000);
        applyStimulus(1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b0);
        @(negedge I_clk);
        checkOutput("ack3.dataRdy", 16'(dataRdy), 16'h0000);

        // Channel sequence 0,1,3 breaks framing; resync at next chan 0
        applyStimulus(1'b1, 0, 16'h300, 1'b0);
        applyStimulus(1'b1, 1, 16'h301, 1'b0);
        applyStimulus(1'b1, 3, 16'h3FF, 1'b0);
        applyStimulus(1'b1, 1, 16'h3FE, 1'b0);
        applyStimulus(1'b1, 0, 16'h3A0, 1'b0);
        applyStimulus(1'b1, 1, 16'h3A1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0);
        @(negedge I_clk);
        checkOutput("sync.syncErr", 16'(syncErr), 16'h0001);
        busRead(16'h0010, 16'h03A0, 2, "resync0", got);
        busRead(16'h0011, 16'h03A1, 2, "resync1", got);

        // Completion in the same cycle as the ack keeps dataRdy set
        fillSamples(2, BANK_DEPTH - 2, 16'h3A0, 1'b1);
        @(negedge I_clk);
        checkOutput("simul.dataRdy", 16'(dataRdy), 16'h0001);
        busRead(STATUS_ADDR, modelStatus(), 2, "statusModel", got);
        checkOutput("status.literal", got, 16'hF400);
        checkOutput("status.dataRdyBit", 16'(got[12]), 16'h0001);

        // Reset in the middle of a read releases the bus and clears flags
        @(posedge I_clk);
        #1;
        bfAddr = STATUS_ADDR; bfSel = 1'b1; bfAre = 1'b1;
        I_rst_n = 1'b0;
        checkFlags = 1'b0;
        @(negedge I_clk);
        checkOutput("midRst.busZ", 16'(busIdle()), 16'h0001);
        @(negedge I_clk);
        checkOutput("midRst.overrun", 16'(overrun), 16'h0000);
        checkOutput("midRst.syncErr", 16'(syncErr), 16'h0000);
        @(posedge I_clk);
        #1;
        bfAre = 1'b0; bfSel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
